// File: rtl/mips_dump_sequencer_pkg.sv
// mips_dbg_pkg: shared definitions for the MIPS state-dump sequencer.
//   state_e     : sequencer FSM encoding (CSUM is only reachable when
//                 DUMP_CHECKSUM_EN is defined)
//   WORD_BYTES  : bytes per dumped word for the default 32-bit word
//   PC_IDX, CLK_IDX, REG_BASE : word-index offsets of each word type
//   word_bytes(): bytes per word for an arbitrary word width
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_WAIT = 3'd4,
    S_CSUM = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam int NBITS_DEFAULT = 32;
  localparam int WORD_BYTES    = NBITS_DEFAULT / 8;

  // Word index layout of a dump: PC, clock count, registers, then memory.
  localparam int PC_IDX   = 0;
  localparam int CLK_IDX  = 1;
  localparam int REG_BASE = 2;

  function automatic int word_bytes(input int nbits);
    return nbits / 8;
  endfunction

endpackage

// File: rtl/mips_dump_sequencer_if.sv
// mips_dump_sequencer_if: UART transmit byte handshake.
//   o_uart_tx_data  : byte to send (master -> slave)
//   o_uart_tx_ready : one-cycle start strobe (master -> slave)
//   i_uart_tx_done  : one-cycle completion strobe (slave -> master)
// Handshake: the master raises o_uart_tx_ready for exactly one cycle with
// o_uart_tx_data valid in that same cycle, then holds o_uart_tx_data until its
// next strobe. It never strobes again until the slave has returned
// i_uart_tx_done for the byte in flight; a done strobe arriving while no byte
// is awaited (including the strobe cycle itself) is ignored by the master.
interface mips_dump_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_uart_tx_data;
  logic                 o_uart_tx_ready;
  logic                 i_uart_tx_done;

  modport master (
    output o_uart_tx_data,
    output o_uart_tx_ready,
    input  i_uart_tx_done
  );

  modport slave (
    input  o_uart_tx_data,
    input  o_uart_tx_ready,
    output i_uart_tx_done
  );
endinterface

// File: rtl/mips_dump_sequencer_shifter.sv
// dump_byte_shifter: holds one dump word and hands it out MSB byte first.
//   i_clear     : drop the remaining byte count (and checksum, if built in)
//   i_load      : load i_word, byte count = NBITS/8
//   i_send      : current byte is going out (folded into the checksum)
//   i_advance   : shift left one byte, decrement count
//   o_byte      : current (most significant) byte
//   o_last      : exactly one byte left
// Optional macro DUMP_CHECKSUM_EN adds i_load_csum (load the running XOR as a
// single-byte word) and o_csum (running XOR of every byte sent).
module dump_byte_shifter
  import mips_dbg_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [NBITS-1:0]     i_word,
`ifdef DUMP_CHECKSUM_EN
  input  logic                 i_load_csum,
  output logic [DATA_BITS-1:0] o_csum,
`endif
  input  logic                 i_send,
  input  logic                 i_advance,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_last
);

  localparam int WB    = word_bytes(NBITS);
  localparam int CNT_W = $clog2(WB + 1);

  logic [NBITS-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_BITS-1:0] r_csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_csum <= '0;
    else if (i_clear) r_csum <= '0;
    else if (i_send)  r_csum <= r_csum ^ o_byte;
  end

  assign o_csum = r_csum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= CNT_W'(WB);
`ifdef DUMP_CHECKSUM_EN
    end else if (i_load_csum) begin
      // Checksum goes out as a one-byte word sitting in the MSB lane.
      r_shift <= {r_csum, {(NBITS-DATA_BITS){1'b0}}};
      r_cnt   <= CNT_W'(1);
`endif
    end else if (i_advance) begin
      r_shift <= r_shift << DATA_BITS;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  assign o_byte = r_shift[NBITS-1 -: DATA_BITS];
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mips_dump_sequencer.sv
// mips_dump_sequencer: streams PC, clock count, every register and every
// data-memory cell out through the UART transmitter after one start pulse.
// Ports:
//   clk, reset (async, active low)
//   i_start / i_abort          : debug-unit control
//   i_mips_pc, i_mips_clk_count: sampled directly in CAP
//   i_mips_reg / i_mips_mem    : read data for o_mips_reg / o_mips_mem
//   o_mips_reg / o_mips_mem    : registered selects (cell index, not address)
//   uart (master modport)      : byte data, start strobe, done strobe
//   o_busy / o_done            : dump in progress / one-cycle completion
//   o_dbg_state                : current FSM state
// Optional macro DUMP_CHECKSUM_EN: appends one XOR-of-all-bytes byte.
module mips_dump_sequencer
  import mips_dbg_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int DATA_BITS  = 8,
  parameter int CELDAS_REG = 32,
  parameter int CELDAS_M   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic [NBITS-1:0]              i_mips_pc,
  input  logic [NBITS-1:0]              i_mips_clk_count,
  input  logic [NBITS-1:0]              i_mips_reg,
  input  logic [NBITS-1:0]              i_mips_mem,
  output logic [$clog2(CELDAS_REG)-1:0] o_mips_reg,
  output logic [NBITS-1:0]              o_mips_mem,
  mips_dump_sequencer_if.master         uart,
  output logic                          o_busy,
  output logic                          o_done,
  output state_e                        o_dbg_state
);

  localparam int N     = REG_BASE + CELDAS_REG + CELDAS_M;
  localparam int W_W   = $clog2(N + 1);
  localparam int REG_W = $clog2(CELDAS_REG);

  state_e               r_state, w_next;
  logic [W_W-1:0]       r_w;
  logic [REG_W-1:0]     r_mips_reg;
  logic [NBITS-1:0]     r_mips_mem;
  logic [DATA_BITS-1:0] r_tx_hold;

  logic                 w_load, w_send, w_adv, w_clear;
  logic [DATA_BITS-1:0] w_byte;
  logic                 w_last_byte;
  logic [NBITS-1:0]     w_word;
  logic                 w_is_reg, w_is_mem, w_last_word;

`ifdef DUMP_CHECKSUM_EN
  logic                 w_load_csum;
  logic [DATA_BITS-1:0] w_csum;
  logic                 r_csum_phase;  // the byte in flight is the checksum
`endif

  assign w_is_reg    = (r_w >= W_W'(REG_BASE)) && (r_w < W_W'(REG_BASE + CELDAS_REG));
  assign w_is_mem    = (r_w >= W_W'(REG_BASE + CELDAS_REG));
  assign w_last_word = (r_w == W_W'(N - 1));

  always_comb begin
    if (r_w == W_W'(PC_IDX))       w_word = i_mips_pc;
    else if (r_w == W_W'(CLK_IDX)) w_word = i_mips_clk_count;
    else if (w_is_reg)             w_word = i_mips_reg;
    else                           w_word = i_mips_mem;
  end

  dump_byte_shifter #(
    .NBITS     (NBITS),
    .DATA_BITS (DATA_BITS)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_word      (w_word),
`ifdef DUMP_CHECKSUM_EN
    .i_load_csum (w_load_csum),
    .o_csum      (w_csum),
`endif
    .i_send      (w_send),
    .i_advance   (w_adv),
    .o_byte      (w_byte),
    .o_last      (w_last_byte)
  );

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_send  = 1'b0;
    w_adv   = 1'b0;
    w_clear = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    w_load_csum = 1'b0;
`endif
    if (i_abort) begin
      // Abort outranks everything, including a simultaneous start in IDLE.
      w_next  = S_IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          w_next  = S_SEL;
          w_clear = 1'b1;
        end
        S_SEL:  w_next = S_CAP;
        S_CAP: begin
          w_load = 1'b1;
          w_next = S_SEND;
        end
        S_SEND: begin
          w_send = 1'b1;
          w_next = S_WAIT;
        end
        S_WAIT: if (uart.i_uart_tx_done) begin
          w_adv = 1'b1;
          if (!w_last_byte) w_next = S_SEND;
          else if (w_last_word) begin
`ifdef DUMP_CHECKSUM_EN
            w_next = r_csum_phase ? S_DONE : S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else w_next = S_SEL;
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          w_load_csum = 1'b1;
          w_next      = S_SEND;
        end
`endif
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_mips_reg <= '0;
      r_mips_mem <= '0;
      r_tx_hold  <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_csum_phase <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      // A byte handed to the UART is not recalled, so keep it even on abort.
      if (r_state == S_SEND) r_tx_hold <= w_byte;
      if (i_abort) begin
        r_w        <= '0;
        r_mips_reg <= '0;
        r_mips_mem <= '0;
`ifdef DUMP_CHECKSUM_EN
        r_csum_phase <= 1'b0;
`endif
      end else begin
        if (r_state == S_IDLE && i_start) begin
          r_w <= '0;
`ifdef DUMP_CHECKSUM_EN
          r_csum_phase <= 1'b0;
`endif
        end
        if (r_state == S_WAIT && w_next == S_SEL) r_w <= r_w + W_W'(1);
        // Selects only move for words that come from the register file or
        // memory; PC/clock words leave them where they were.
        if (r_state == S_SEL && w_is_reg)
          r_mips_reg <= REG_W'(r_w - W_W'(REG_BASE));
        if (r_state == S_SEL && w_is_mem)
          r_mips_mem <= NBITS'(r_w - W_W'(REG_BASE + CELDAS_REG));
`ifdef DUMP_CHECKSUM_EN
        if (r_state == S_CSUM) r_csum_phase <= 1'b1;
`endif
      end
    end
  end

  assign uart.o_uart_tx_ready = (r_state == S_SEND);
  assign uart.o_uart_tx_data  = (r_state == S_SEND) ? w_byte : r_tx_hold;
  assign o_mips_reg  = r_mips_reg;
  assign o_mips_mem  = r_mips_mem;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mips_dump_sequencer.sv
// Bench for mips_dump_sequencer with 2 registers and 2 memory cells.
// Optional macro DUMP_CHECKSUM_EN: expects a 25th checksum byte.
module tb_mips_dump_sequencer;
  import mips_dbg_pkg::*;

  localparam int NBITS      = 32;
  localparam int DATA_BITS  = 8;
  localparam int CELDAS_REG = 2;
  localparam int CELDAS_M   = 2;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = 25;
`else
  localparam int NB = 24;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_start, i_abort;
  logic [31:0] pc_v, clk_v;
  logic [31:0] regs_a[2];
  logic [31:0] mem_a[2];
  logic [31:0] mips_reg_data, mips_mem_data;
  logic [0:0]  o_mips_reg;
  logic [31:0] o_mips_mem;
  logic        o_busy, o_done;
  state_e      dbg_state;
  logic        uart_done_m, inj_done;

  mips_dump_sequencer_if #(.DATA_BITS(DATA_BITS)) uif ();
  assign uif.i_uart_tx_done = uart_done_m | inj_done;

  // MIPS debug read ports: data follows the selects.
  assign mips_reg_data = regs_a[o_mips_reg];
  assign mips_mem_data = (o_mips_mem < 32'd2) ? mem_a[o_mips_mem[0]] : 32'h0;

  mips_dump_sequencer #(
    .NBITS      (NBITS),
    .DATA_BITS  (DATA_BITS),
    .CELDAS_REG (CELDAS_REG),
    .CELDAS_M   (CELDAS_M)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_mips_pc        (pc_v),
    .i_mips_clk_count (clk_v),
    .i_mips_reg       (mips_reg_data),
    .i_mips_mem       (mips_mem_data),
    .o_mips_reg       (o_mips_reg),
    .o_mips_mem       (o_mips_mem),
    .uart             (uif),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- UART model + byte capture ----------------
  logic [7:0] got_q[$];
  int ready_count, done_cnt, u_cnt;

  initial begin
    uart_done_m = 1'b0;
    u_cnt       = 0;
    ready_count = 0;
    done_cnt    = 0;
    forever begin
      @(negedge clk);
      uart_done_m = 1'b0;
      if (!reset) u_cnt = 0;
      else begin
        if (u_cnt != 0) begin
          u_cnt--;
          if (u_cnt == 0) uart_done_m = 1'b1;
        end
        if (uif.o_uart_tx_ready) begin
          got_q.push_back(uif.o_uart_tx_data);
          ready_count++;
          u_cnt = 3;
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  clk_cnt;
    logic [31:0]  r0, r1, m0, m1;
    int           mode;        // 0 plain, 1 repeated start, 2 stray done pulses
    logic [191:0] exp_stream;  // the 24 data bytes, first byte in the MSBs
    logic [7:0]   exp_csum;
  } vec_t;

  vec_t vecs[4];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_data(input vec_t v);
    pc_v      = v.pc;
    clk_v     = v.clk_cnt;
    regs_a[0] = v.r0;
    regs_a[1] = v.r1;
    mem_a[0]  = v.m0;
    mem_a[1]  = v.m1;
  endtask

  task automatic run_dump(input vec_t v, input string tag);
    int rc0;
    logic [191:0] s;
    logic [31:0]  exp_b, act_b;
    load_data(v);
    got_q.delete();
    done_cnt = 0;
    rc0      = ready_count;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, " busy after start"}, 32'(o_busy), 32'd1);
    for (int c = 0; c < 3000; c++) begin
      tick();
      i_start  = 1'b0;
      inj_done = 1'b0;
      if (done_cnt != 0) break;
      if (v.mode == 1 && (c % 5) == 0 && dbg_state != S_IDLE && dbg_state != S_DONE)
        i_start = 1'b1;
      if (v.mode == 2 && (dbg_state == S_SEL || dbg_state == S_CAP || dbg_state == S_SEND))
        inj_done = 1'b1;
    end
    i_start  = 1'b0;
    inj_done = 1'b0;
    repeat (3) tick();
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy after done"}, 32'(o_busy), 32'd0);
    check({tag, " state after done"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, " byte count"}, 32'(ready_count - rc0), 32'(NB));
    s = v.exp_stream;
    for (int i = 0; i < NB; i++) begin
      if (i < 24) exp_b = 32'(s[191 - 8*i -: 8]);
      else        exp_b = 32'(v.exp_csum);
      act_b = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD0000;
      check($sformatf("%s byte %0d", tag, i), act_b, exp_b);
    end
  endtask

  task automatic abort_at(input int n, input logic [31:0] exp_reg, input string tag);
    int rc0, rc1;
    load_data(vecs[0]);
    done_cnt = 0;
    rc0      = ready_count;
    i_start  = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 2000 && (ready_count - rc0) < n; c++) tick();
    check({tag, " bytes before abort"}, 32'(ready_count - rc0), 32'(n));
    check({tag, " reg select before abort"}, 32'(o_mips_reg), exp_reg);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check({tag, " state after abort"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, " busy after abort"}, 32'(o_busy), 32'd0);
    check({tag, " reg select after abort"}, 32'(o_mips_reg), 32'd0);
    check({tag, " mem select after abort"}, 32'(o_mips_mem), 32'd0);
    rc1 = ready_count;
    repeat (20) tick();
    check({tag, " no done after abort"}, 32'(done_cnt), 32'd0);
    check({tag, " no bytes after abort"}, 32'(ready_count - rc1), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rc;
    reset    = 1'b0;
    i_start  = 1'b0;
    i_abort  = 1'b0;
    inj_done = 1'b0;

    vecs[0] = '{pc: 32'h00000010, clk_cnt: 32'h00000005, r0: 32'h11223344, r1: 32'hAABBCCDD,
                m0: 32'h00000001, m1: 32'h00000002, mode: 0,
                exp_stream: 192'h00000010_00000005_11223344_AABBCCDD_00000001_00000002,
                exp_csum: 8'h52};
    vecs[1] = '{pc: 32'hDEADBEEF, clk_cnt: 32'h01020304, r0: 32'h00000000, r1: 32'hFFFFFFFF,
                m0: 32'h80000001, m1: 32'h7F00FF00, mode: 0,
                exp_stream: 192'hDEADBEEF_01020304_00000000_FFFFFFFF_80000001_7F00FF00,
                exp_csum: 8'h27};
    vecs[2] = vecs[0];
    vecs[2].mode = 1;
    vecs[3] = vecs[0];
    vecs[3].mode = 2;
    load_data(vecs[0]);

    // Reset state
    #12;
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset tx_ready", 32'(uif.o_uart_tx_ready), 32'd0);
    check("reset tx_data", 32'(uif.o_uart_tx_data), 32'd0);
    check("reset reg select", 32'(o_mips_reg), 32'd0);
    check("reset state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    check("idle after reset release", 32'(dbg_state), 32'(S_IDLE));

    // Start and abort together in IDLE: abort wins
    rc      = ready_count;
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    check("start+abort state", 32'(dbg_state), 32'(S_IDLE));
    check("start+abort busy", 32'(o_busy), 32'd0);
    repeat (5) tick();
    check("start+abort no bytes", 32'(ready_count - rc), 32'd0);

    abort_at(6, 32'd0, "abort6");

    foreach (vecs[k]) run_dump(vecs[k], $sformatf("vec%0d", k));

    abort_at(14, 32'd1, "abort14");
    run_dump(vecs[0], "restart");

    // Reset mid-byte, while the first byte of register 1 is with the UART
    load_data(vecs[0]);
    rc      = ready_count;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 2000 && (ready_count - rc) < 13; c++) tick();
    check("pre-reset tx_data hold", 32'(uif.o_uart_tx_data), 32'hAA);
    check("pre-reset reg select", 32'(o_mips_reg), 32'd1);
    reset = 1'b0;
    #1;
    check("async reset busy", 32'(o_busy), 32'd0);
    check("async reset tx_ready", 32'(uif.o_uart_tx_ready), 32'd0);
    check("async reset tx_data", 32'(uif.o_uart_tx_data), 32'd0);
    check("async reset reg select", 32'(o_mips_reg), 32'd0);
    check("async reset mem select", 32'(o_mips_mem), 32'd0);
    check("async reset state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    reset = 1'b1;
    rc    = ready_count;
    repeat (10) tick();
    check("post-reset idle", 32'(dbg_state), 32'(S_IDLE));
    check("post-reset busy", 32'(o_busy), 32'd0);
    check("post-reset no bytes", 32'(ready_count - rc), 32'd0);
    run_dump(vecs[1], "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
